// File: rtl/full_adder_32bit_pkg.sv
// Shared constants for the ripple-carry adder slice.
package full_adder_32bit_pkg;
  localparam int WIDTH_DEFAULT = 32;
endpackage : full_adder_32bit_pkg

// File: rtl/full_adder_32bit_if.sv
// Operand/result bundle of the adder: the master drives operands and carry-in,
// the slave (the adder) returns the registered sum and carry-out.
import full_adder_32bit_pkg::*;

interface full_adder_32bit_if #(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] S;
  logic             Cout;

  modport master (
    output A, B, Cin,
    input  S, Cout
  );

  modport slave (
    input  A, B, Cin,
    output S, Cout
  );
endinterface : full_adder_32bit_if

// File: rtl/full_adder_32bit_full_adder_1bit.sv
// One bit of the ripple chain: sum and carry-out of a, b and the incoming carry.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic half_sum;

  // Propagate term is shared between the sum and the carry-out.
  always_comb begin
    half_sum = a ^ b;
    s        = half_sum ^ cin;
    cout     = (a & b) | (cin & half_sum);
  end
endmodule : full_adder_1bit

// File: rtl/full_adder_32bit.sv
// Registered ripple-carry adder: {Cout,S} = A + B + Cin, one cycle of latency,
// a new addition accepted on every rising edge.
import full_adder_32bit_pkg::*;

module full_adder_32bit #(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  full_adder_32bit_if.slave   bus
);
  // carry[0] is the carry-in, carry[WIDTH] the carry-out of the top bit.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] s_reg;
  logic             cout_reg;

  assign carry[0] = bus.Cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      full_adder_1bit u_fa (
        .a    (bus.A[gi]),
        .b    (bus.B[gi]),
        .cin  (carry[gi]),
        .s    (sum_next[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  // Output register; reset clears any in-flight result immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg    <= '0;
      cout_reg <= 1'b0;
    end else begin
      s_reg    <= sum_next;
      cout_reg <= carry[WIDTH];
    end
  end

  assign bus.S    = s_reg;
  assign bus.Cout = cout_reg;
endmodule : full_adder_32bit

// File: tb/tb_full_adder_32bit.sv
// Directed and streaming checks of the registered 32-bit adder.
module tb_full_adder_32bit;
  logic clk;
  logic rst_n;

  full_adder_32bit_if #(.WIDTH(32)) ifc ();

  full_adder_32bit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        cout;
  } vec_t;

  vec_t vecs [7];
  int   n_vec;
  int   n_err;

  task automatic check(input string name, input int idx,
                       input logic [31:0] exp_s, input logic exp_c);
    n_vec++;
    if (ifc.S !== exp_s || ifc.Cout !== exp_c) begin
      n_err++;
      $display("FAIL %s[%0d]: got S=%h Cout=%b, expected S=%h Cout=%b",
               name, idx, ifc.S, ifc.Cout, exp_s, exp_c);
    end else begin
      $display("ok   %s[%0d]: S=%h Cout=%b", name, idx, ifc.S, ifc.Cout);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin);
    ifc.A   = a;
    ifc.B   = b;
    ifc.Cin = cin;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [32:0] ref_sum;
    logic [31:0] ra, rb;
    logic        rc;

    n_vec = 0;
    n_err = 0;

    vecs[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1};
    vecs[5] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};

    // Reset held with operands that would produce a nonzero result.
    rst_n = 1'b0;
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", i, 32'h0, 1'b0);
    end
    rst_n = 1'b1;
    #2;
    check("release_pre_edge", 0, 32'h0, 1'b0);
    tick();
    check("release_first", 0, 32'h0000_0001, 1'b1);

    // Directed table, one vector per cycle.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].cin);
      tick();
      check("vec", i, vecs[i].s, vecs[i].cout);
    end

    // Latency: a new input must not show before the capturing edge.
    drive(32'h0, 32'h0, 1'b0);
    tick();
    drive(32'h0, 32'h0, 1'b1);
    #2;
    check("latency_hold", 0, 32'h0, 1'b0);
    tick();
    check("latency_cap", 0, 32'h1, 1'b0);

    // Random streaming with a one-cycle reset pulse in the middle.
    for (int i = 0; i < 30; i++) begin
      ra = $urandom();
      rb = $urandom();
      rc = i[0];
      if (i == 15) begin
        rst_n = 1'b0;
        #1;
        check("stream_async_rst", i, 32'h0, 1'b0);
        drive(ra, rb, rc);
        tick();
        check("stream_rst_hold", i, 32'h0, 1'b0);
        rst_n = 1'b1;
        ra = $urandom();
        rb = $urandom();
      end
      drive(ra, rb, rc);
      ref_sum = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
      tick();
      check("stream", i, ref_sum[31:0], ref_sum[32]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule : tb_full_adder_32bit
